// File: rtl/countdown_timer.sv
// ============================================================================
//  Module      : countdown_timer
//  Description : Preset min:sec countdown at 0.1 s resolution with run/pause
//                toggle, stop/reload and a done flag.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module countdown_timer #(
    parameter int TICK_DIV = 5_000_000
) (
    input  logic       Clk,
    input  logic       Rst,
    input  logic       fStart,
    input  logic       fStop,
    input  logic [5:0] iPresetMin,
    input  logic [5:0] iPresetSec,
    output logic [5:0] oMin,
    output logic [5:0] oSec,
    output logic [3:0] oTenth,
    output logic       oRun,
    output logic       oDone
);

    localparam int c_presc_w = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [c_presc_w-1:0] c_tick_last = c_presc_w'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_PAUSE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                 state_q, state_d;
    logic [c_presc_w-1:0]   presc_q, presc_d;
    logic [5:0]             min_q, min_d;
    logic [5:0]             sec_q, sec_d;
    logic [3:0]             tenth_q, tenth_d;
    logic                   start_hist_q, start_hist_d;
    logic                   stop_hist_q, stop_hist_d;

    logic       start_press, stop_press, tick;
    logic [5:0] preset_min_sat, preset_sec_sat;
    logic       preset_zero;
    logic [5:0] dec_min, dec_sec;
    logic [3:0] dec_tenth;
    logic       dec_zero;

    assign start_press    = start_hist_q & ~fStart;
    assign stop_press     = stop_hist_q & ~fStop;
    assign tick           = (presc_q == c_tick_last);
    assign preset_min_sat = (iPresetMin > 6'd59) ? 6'd59 : iPresetMin;
    assign preset_sec_sat = (iPresetSec > 6'd59) ? 6'd59 : iPresetSec;
    assign preset_zero    = (preset_min_sat == 6'd0) && (preset_sec_sat == 6'd0);

    // One-tenth decrement with borrow; minutes never go below zero.
    always_comb begin
        dec_min   = min_q;
        dec_sec   = sec_q;
        dec_tenth = tenth_q;
        if (tenth_q != 4'd0) begin
            dec_tenth = tenth_q - 4'd1;
        end else begin
            dec_tenth = 4'd9;
            if (sec_q != 6'd0) begin
                dec_sec = sec_q - 6'd1;
            end else begin
                dec_sec = 6'd59;
                if (min_q != 6'd0) begin
                    dec_min = min_q - 6'd1;
                end
            end
        end
        dec_zero = (dec_min == 6'd0) && (dec_sec == 6'd0) && (dec_tenth == 4'd0);
    end

    always_comb begin
        state_d      = state_q;
        presc_d      = presc_q;
        min_d        = min_q;
        sec_d        = sec_q;
        tenth_d      = tenth_q;
        start_hist_d = fStart;
        stop_hist_d  = fStop;

        case (state_q)
            S_IDLE: begin
                min_d   = preset_min_sat;
                sec_d   = preset_sec_sat;
                tenth_d = 4'd0;
                if (start_press && !stop_press && !preset_zero) begin
                    state_d = S_RUN;
                    presc_d = '0;
                end
            end
            S_RUN: begin
                if (stop_press) begin
                    state_d = S_IDLE;
                end else begin
                    presc_d = tick ? '0 : presc_q + c_presc_w'(1);
                    if (tick) begin
                        min_d   = dec_min;
                        sec_d   = dec_sec;
                        tenth_d = dec_tenth;
                    end
                    // Reaching zero takes precedence over a coincident pause.
                    if (tick && dec_zero) begin
                        state_d = S_DONE;
                    end else if (start_press) begin
                        state_d = S_PAUSE;
                    end
                end
            end
            S_PAUSE: begin
                if (stop_press) begin
                    state_d = S_IDLE;
                end else if (start_press) begin
                    state_d = S_RUN;
                end
            end
            S_DONE: begin
                if (stop_press || start_press) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!Rst) begin
            state_q      <= S_IDLE;
            presc_q      <= '0;
            min_q        <= 6'd0;
            sec_q        <= 6'd0;
            tenth_q      <= 4'd0;
            start_hist_q <= 1'b1;
            stop_hist_q  <= 1'b1;
        end else begin
            state_q      <= state_d;
            presc_q      <= presc_d;
            min_q        <= min_d;
            sec_q        <= sec_d;
            tenth_q      <= tenth_d;
            start_hist_q <= start_hist_d;
            stop_hist_q  <= stop_hist_d;
        end
    end

    assign oMin   = min_q;
    assign oSec   = sec_q;
    assign oTenth = tenth_q;
    assign oRun   = (state_q == S_RUN);
    assign oDone  = (state_q == S_DONE);

endmodule

`default_nettype wire
